// File: rtl/coffee_pkg.sv
// Shared types for the coffee order scheduler: drink codes and dispatcher states.
package coffee_pkg;

  typedef enum logic [1:0] {
    ESPRESSO    = 2'b00,
    LATTE       = 2'b01,
    CAPUCHINO   = 2'b10,
    SEL_INVALID = 2'b11
  } coffee_sel_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } disp_state_t;

  // Codes that may be queued and brewed.
  function automatic logic sel_is_valid(input logic [1:0] sel);
    return sel != SEL_INVALID;
  endfunction

endpackage

// File: rtl/coffee_order_scheduler_fifo.sv
// order_fifo: DEPTH x W storage with wrap-around pointers and an occupancy count.
// The caller never pushes when full nor pops when empty.
module order_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [W-1:0]               i_push_data,
  input  logic                       i_pop,
  output logic [W-1:0]               o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][W-1:0] r_mem;
  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_count;

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (i_push && !i_pop)      r_count <= r_count + 1'b1;
      else if (!i_push && i_pop) r_count <= r_count - 1'b1;
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/coffee_order_scheduler.sv
// coffee_order_scheduler: round-robin order intake, order FIFO, and brewer
// sequencing (start pulse, held selection, wait for done, enforced idle gap).
// Optional macro COFFEE_STATS_EN adds saturating per-drink served counters.
module coffee_order_scheduler
  import coffee_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [2*NUM_REQ-1:0]       req_sel,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       brew_start,
  output logic [1:0]                 brew_sel,
  input  logic                       brew_done,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] queue_count,
  output logic                       order_reject
`ifdef COFFEE_STATS_EN
  ,
  output logic [7:0]                 served_e,
  output logic [7:0]                 served_l,
  output logic [7:0]                 served_c
`endif
);
  localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int GAP_W = $clog2(GAP_CYCLES);

  logic [RR_W-1:0]  r_rr;
  logic             r_reject;
  logic [1:0]       r_brew_sel;
  logic [GAP_W-1:0] r_gap_cnt;
  disp_state_t      r_state;
  disp_state_t      w_state_nxt;

  logic [NUM_REQ-1:0] w_grant;
  logic               w_accept;
  logic [1:0]         w_acc_sel;
  logic [RR_W-1:0]    w_rr_nxt;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_start;
  logic               w_load_gap;
  logic               w_done_ev;
  logic [1:0]         w_head;
  logic [CNT_W-1:0]   w_count;

  assign w_full = (w_count == CNT_W'(DEPTH));

  // Round-robin search from the pointer; no grant while full or in reset.
  always_comb begin
    int idx;
    idx       = 0;
    w_grant   = '0;
    w_accept  = 1'b0;
    w_acc_sel = 2'b00;
    w_rr_nxt  = r_rr;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(r_rr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_accept && req_valid[idx]) begin
        w_accept     = 1'b1;
        w_grant[idx] = 1'b1;
        w_acc_sel    = req_sel[2*idx +: 2];
        w_rr_nxt     = (idx == NUM_REQ-1) ? '0 : RR_W'(idx + 1);
      end
    end
    if (reset || w_full) begin
      w_grant  = '0;
      w_accept = 1'b0;
      w_rr_nxt = r_rr;
    end
  end

  assign w_push = w_accept && sel_is_valid(w_acc_sel);

  order_fifo #(.DEPTH(DEPTH), .W(2)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (w_acc_sel),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  // Pointer advance and one-cycle-late reject pulse for dropped invalid orders.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr     <= '0;
      r_reject <= 1'b0;
    end else begin
      r_rr     <= w_rr_nxt;
      r_reject <= w_accept && !sel_is_valid(w_acc_sel);
    end
  end

  // Dispatcher state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Dispatcher next-state and control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_start     = 1'b0;
    w_load_gap  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_count != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        w_start     = 1'b1;
        w_state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (brew_done) begin
          w_load_gap  = 1'b1;
          w_state_nxt = GAP;
        end
      end
      GAP: begin
        if (r_gap_cnt == '0) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Selection latched on pop and held until the next pop; gap countdown.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_brew_sel <= 2'b00;
      r_gap_cnt  <= '0;
    end else begin
      if (w_pop) r_brew_sel <= w_head;
      if (w_load_gap)                            r_gap_cnt <= GAP_W'(GAP_CYCLES - 1);
      else if (r_state == GAP && r_gap_cnt != '0) r_gap_cnt <= r_gap_cnt - 1'b1;
    end
  end

  assign w_done_ev = (r_state == WAIT_DONE) && brew_done;

`ifdef COFFEE_STATS_EN
  logic [7:0] r_served_e;
  logic [7:0] r_served_l;
  logic [7:0] r_served_c;

  // Completed-drink counters, saturating at 255.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_served_e <= '0;
      r_served_l <= '0;
      r_served_c <= '0;
    end else if (w_done_ev) begin
      if (r_brew_sel == ESPRESSO  && r_served_e != 8'hFF) r_served_e <= r_served_e + 1'b1;
      if (r_brew_sel == LATTE     && r_served_l != 8'hFF) r_served_l <= r_served_l + 1'b1;
      if (r_brew_sel == CAPUCHINO && r_served_c != 8'hFF) r_served_c <= r_served_c + 1'b1;
    end
  end

  assign served_e = r_served_e;
  assign served_l = r_served_l;
  assign served_c = r_served_c;
`else
  logic w_unused_done_ev;
  assign w_unused_done_ev = w_done_ev;
`endif

  assign req_ready    = w_grant;
  assign brew_start   = w_start;
  assign brew_sel     = r_brew_sel;
  assign busy         = (r_state != IDLE);
  assign queue_count  = w_count;
  assign order_reject = r_reject;

endmodule

// File: tb/tb_coffee_order_scheduler.sv
// Directed bench for coffee_order_scheduler (NUM_REQ=2, DEPTH=4, GAP_CYCLES=2).
// Inputs change just after the falling edge; outputs are checked 1ns later.
module tb_coffee_order_scheduler;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req_valid;
  logic [3:0] req_sel;
  logic [1:0] req_ready;
  logic       brew_start;
  logic [1:0] brew_sel;
  logic       brew_done;
  logic       busy;
  logic [2:0] queue_count;
  logic       order_reject;
`ifdef COFFEE_STATS_EN
  logic [7:0] served_e, served_l, served_c;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  coffee_order_scheduler #(.NUM_REQ(2), .DEPTH(4), .GAP_CYCLES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_sel      (req_sel),
    .req_ready    (req_ready),
    .brew_start   (brew_start),
    .brew_sel     (brew_sel),
    .brew_done    (brew_done),
    .busy         (busy),
    .queue_count  (queue_count),
    .order_reject (order_reject)
`ifdef COFFEE_STATS_EN
    ,
    .served_e     (served_e),
    .served_l     (served_l),
    .served_c     (served_c)
`endif
  );

  always #5 clk = ~clk;

  // One cycle: drive inputs after the falling edge, settle, then caller checks.
  task automatic go(input logic r, input logic [1:0] v, input logic [3:0] s, input logic d);
    @(negedge clk);
    reset = r; req_valid = v; req_sel = s; brew_done = d;
    #1;
  endtask

  task automatic do_reset();
    go(1'b1, 2'b00, 4'h0, 1'b0);
    go(1'b1, 2'b00, 4'h0, 1'b0);
    go(1'b0, 2'b00, 4'h0, 1'b0);
  endtask

  task automatic test_reset();
    go(1'b1, 2'b11, 4'h0, 1'b0);
    n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_ready_in_reset got=%b exp=00", req_ready); end
    go(1'b1, 2'b11, 4'h0, 1'b1);
    go(1'b0, 2'b00, 4'h0, 1'b0);
    n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_ready got=%b exp=00", req_ready); end
    n_tests++; if (brew_start !== 1'b0) begin n_fail++; $display("FAIL rst_start got=%b exp=0", brew_start); end
    n_tests++; if (brew_sel !== 2'b00) begin n_fail++; $display("FAIL rst_sel got=%b exp=00", brew_sel); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
    n_tests++; if (queue_count !== 3'd0) begin n_fail++; $display("FAIL rst_count got=%0d exp=0", queue_count); end
    n_tests++; if (order_reject !== 1'b0) begin n_fail++; $display("FAIL rst_reject got=%b exp=0", order_reject); end
  endtask

  task automatic test_single();
    do_reset();
    go(1'b0, 2'b01, 4'b0001, 1'b0);  // c0: panel0 latte
    n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready got=%b exp=01", req_ready); end
    go(1'b0, 2'b00, 4'h0, 1'b0);     // c1: queued, popping
    n_tests++; if (queue_count !== 3'd1) begin n_fail++; $display("FAIL single_count1 got=%0d exp=1", queue_count); end
    n_tests++; if (brew_start !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_c1 got start=%b busy=%b exp 0 0", brew_start, busy); end
    go(1'b0, 2'b00, 4'h0, 1'b0);     // c2: ISSUE
    n_tests++; if (brew_start !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL single_start got start=%b busy=%b exp 1 1", brew_start, busy); end
    n_tests++; if (brew_sel !== 2'b01) begin n_fail++; $display("FAIL single_sel got=%b exp=01", brew_sel); end
    n_tests++; if (queue_count !== 3'd0) begin n_fail++; $display("FAIL single_count0 got=%0d exp=0", queue_count); end
    go(1'b0, 2'b00, 4'h0, 1'b0);     // c3: WAIT_DONE
    n_tests++; if (brew_start !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_wait got start=%b busy=%b exp 0 1", brew_start, busy); end
    go(1'b0, 2'b00, 4'h0, 1'b0);
    go(1'b0, 2'b00, 4'h0, 1'b0);
    go(1'b0, 2'b00, 4'h0, 1'b1);     // c6: done
    n_tests++; if (brew_sel !== 2'b01 || busy !== 1'b1) begin n_fail++; $display("FAIL single_hold got sel=%b busy=%b exp 01 1", brew_sel, busy); end
    go(1'b0, 2'b00, 4'h0, 1'b0);     // c7: GAP
    n_tests++; if (busy !== 1'b1 || brew_start !== 1'b0) begin n_fail++; $display("FAIL single_gap1 got busy=%b start=%b exp 1 0", busy, brew_start); end
    go(1'b0, 2'b00, 4'h0, 1'b0);     // c8: GAP
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_gap2 got busy=%b exp=1", busy); end
    go(1'b0, 2'b00, 4'h0, 1'b0);     // c9: IDLE
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle got busy=%b exp=0", busy); end
    n_tests++; if (brew_sel !== 2'b01) begin n_fail++; $display("FAIL single_sel_kept got=%b exp=01", brew_sel); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_rdy [6];
    logic [2:0] exp_cnt [6];
    exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00};
    exp_cnt = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
    go(1'b1, 2'b11, 4'b1000, 1'b0);
    go(1'b1, 2'b11, 4'b1000, 1'b0);
    for (int c = 0; c < 6; c++) begin
      go(1'b0, 2'b11, 4'b1000, (c == 5));  // panel0 espresso, panel1 capuchino
      n_tests++; if (req_ready !== exp_rdy[c]) begin n_fail++; $display("FAIL rr_ready c%0d got=%b exp=%b", c, req_ready, exp_rdy[c]); end
      n_tests++; if (queue_count !== exp_cnt[c]) begin n_fail++; $display("FAIL rr_count c%0d got=%0d exp=%0d", c, queue_count, exp_cnt[c]); end
    end
    go(1'b0, 2'b11, 4'b1000, 1'b0);  // c6 GAP
    go(1'b0, 2'b11, 4'b1000, 1'b0);  // c7 GAP
    n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rr_full_ready got=%b exp=00", req_ready); end
    go(1'b0, 2'b11, 4'b1000, 1'b0);  // c8 IDLE pops while full
    n_tests++; if (req_ready !== 2'b00 || busy !== 1'b0 || queue_count !== 3'd4) begin n_fail++; $display("FAIL rr_pop_full got rdy=%b busy=%b cnt=%0d exp 00 0 4", req_ready, busy, queue_count); end
    go(1'b0, 2'b11, 4'b1000, 1'b0);  // c9 ISSUE second order
    n_tests++; if (brew_start !== 1'b1 || brew_sel !== 2'b10) begin n_fail++; $display("FAIL rr_second got start=%b sel=%b exp 1 10", brew_start, brew_sel); end
    n_tests++; if (queue_count !== 3'd3 || req_ready !== 2'b10) begin n_fail++; $display("FAIL rr_after_pop got cnt=%0d rdy=%b exp 3 10", queue_count, req_ready); end
    go(1'b0, 2'b00, 4'h0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_sel [3];
    int n;
    exp_sel = '{2'b00, 2'b10, 2'b01};
    do_reset();
    go(1'b0, 2'b01, 4'b0000, 1'b0);
    go(1'b0, 2'b01, 4'b0010, 1'b0);
    n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL b2b_ready got=%b exp=01", req_ready); end
    go(1'b0, 2'b01, 4'b0001, 1'b0);
    n_tests++; if (brew_start !== 1'b1 || brew_sel !== exp_sel[0]) begin n_fail++; $display("FAIL b2b_start0 got start=%b sel=%b exp 1 %b", brew_start, brew_sel, exp_sel[0]); end
    for (int k = 0; k < 3; k++) begin
      go(1'b0, 2'b00, 4'h0, 1'b0);
      go(1'b0, 2'b00, 4'h0, 1'b0);
      go(1'b0, 2'b00, 4'h0, 1'b0);
      go(1'b0, 2'b00, 4'h0, 1'b1);  // done 4 cycles after start
      if (k < 2) begin
        n = 0;
        do begin
          go(1'b0, 2'b00, 4'h0, 1'b0);
          n++;
        end while (brew_start !== 1'b1 && n < 20);
        n_tests++; if (n != 4) begin n_fail++; $display("FAIL b2b_spacing%0d got=%0d exp=4", k+1, n); end
        n_tests++; if (brew_sel !== exp_sel[k+1]) begin n_fail++; $display("FAIL b2b_sel%0d got=%b exp=%b", k+1, brew_sel, exp_sel[k+1]); end
      end
    end
    go(1'b0, 2'b00, 4'h0, 1'b0);
    go(1'b0, 2'b00, 4'h0, 1'b0);
    go(1'b0, 2'b00, 4'h0, 1'b0);
    n_tests++; if (busy !== 1'b0 || queue_count !== 3'd0) begin n_fail++; $display("FAIL b2b_drained got busy=%b cnt=%0d exp 0 0", busy, queue_count); end
  endtask

  task automatic test_invalid();
    do_reset();
    go(1'b0, 2'b10, 4'b1100, 1'b0);
    n_tests++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL inv_ready got=%b exp=10", req_ready); end
    go(1'b0, 2'b00, 4'h0, 1'b0);
    n_tests++; if (order_reject !== 1'b1 || queue_count !== 3'd0) begin n_fail++; $display("FAIL inv_reject got rej=%b cnt=%0d exp 1 0", order_reject, queue_count); end
    go(1'b0, 2'b11, 4'b0000, 1'b0);
    n_tests++; if (order_reject !== 1'b0 || brew_start !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL inv_after got rej=%b start=%b busy=%b exp 0 0 0", order_reject, brew_start, busy); end
    n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL inv_rr_advance got=%b exp=01", req_ready); end
    go(1'b0, 2'b00, 4'h0, 1'b0);
    n_tests++; if (order_reject !== 1'b0 || queue_count !== 3'd1) begin n_fail++; $display("FAIL inv_valid_push got rej=%b cnt=%0d exp 0 1", order_reject, queue_count); end
  endtask

  task automatic test_reset_mid_brew();
    do_reset();
    go(1'b0, 2'b01, 4'b0001, 1'b0);
    go(1'b0, 2'b01, 4'b0010, 1'b0);
    go(1'b0, 2'b01, 4'b0000, 1'b0);
    go(1'b0, 2'b00, 4'h0, 1'b0);  // WAIT_DONE, two queued
    n_tests++; if (busy !== 1'b1 || queue_count !== 3'd2) begin n_fail++; $display("FAIL mid_pre got busy=%b cnt=%0d exp 1 2", busy, queue_count); end
    go(1'b1, 2'b00, 4'h0, 1'b0);
    go(1'b0, 2'b00, 4'h0, 1'b1);  // spurious done right after reset
    n_tests++; if (busy !== 1'b0 || queue_count !== 3'd0 || brew_start !== 1'b0) begin n_fail++; $display("FAIL mid_post got busy=%b cnt=%0d start=%b exp 0 0 0", busy, queue_count, brew_start); end
    n_tests++; if (brew_sel !== 2'b00 || order_reject !== 1'b0 || req_ready !== 2'b00) begin n_fail++; $display("FAIL mid_post_out got sel=%b rej=%b rdy=%b exp 00 0 00", brew_sel, order_reject, req_ready); end
    for (int c = 0; c < 3; c++) begin
      go(1'b0, 2'b00, 4'h0, 1'b0);
      n_tests++; if (busy !== 1'b0 || brew_start !== 1'b0) begin n_fail++; $display("FAIL mid_quiet c%0d got busy=%b start=%b exp 0 0", c, busy, brew_start); end
    end
  endtask

`ifdef COFFEE_STATS_EN
  task automatic run_one(input logic [1:0] sel);
    int n;
    go(1'b0, 2'b01, {2'b00, sel}, 1'b0);
    n = 0;
    do begin go(1'b0, 2'b00, 4'h0, 1'b0); n++; end while (brew_start !== 1'b1 && n < 20);
    if (n >= 20) begin n_tests++; n_fail++; $display("FAIL stats_start_timeout got=none exp=start"); end
    go(1'b0, 2'b00, 4'h0, 1'b1);
    n = 0;
    do begin go(1'b0, 2'b00, 4'h0, 1'b0); n++; end while (busy !== 1'b0 && n < 20);
    if (n >= 20) begin n_tests++; n_fail++; $display("FAIL stats_idle_timeout got=busy exp=idle"); end
  endtask

  task automatic test_stats();
    do_reset();
    n_tests++; if (served_e !== 8'd0 || served_l !== 8'd0 || served_c !== 8'd0) begin n_fail++; $display("FAIL stats_reset got %0d %0d %0d exp 0 0 0", served_e, served_l, served_c); end
    run_one(2'b00);
    run_one(2'b10);
    run_one(2'b00);
    n_tests++; if (served_e !== 8'd2 || served_l !== 8'd0 || served_c !== 8'd1) begin n_fail++; $display("FAIL stats_mix got %0d %0d %0d exp 2 0 1", served_e, served_l, served_c); end
    for (int i = 0; i < 256; i++) run_one(2'b01);
    n_tests++; if (served_l !== 8'd255) begin n_fail++; $display("FAIL stats_sat got=%0d exp=255", served_l); end
  endtask
`endif

  initial begin
    reset = 1'b1; req_valid = '0; req_sel = '0; brew_done = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_invalid();
    test_reset_mid_brew();
`ifdef COFFEE_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
